// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: parity-bit count, data-bit placement and the error classification enum.
package ecc_pkg;

  typedef enum logic [1:0] {CLEAN, SB, DB} ecc_class_e;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int parity_bits(input int data_w);
    for (int p = 1; p < 16; p++) begin
      if ((1 << p) >= data_w + p + 1) return p;
    end
    return 16;
  endfunction

  // Hamming position of data bit k: the k-th index (from 1 up) that is not a power of two.
  function automatic int data_pos(input int k);
    int cnt;
    cnt = 0;
    for (int i = 3; i < 128; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == k) return i;
        cnt++;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/ecc_secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a SECDED codeword (bit 0 = overall parity).
module ecc_secded_syndrome
  import ecc_pkg::*;
#(
  parameter int CW_W = 13,
  parameter int P    = 4
) (
  input  logic [CW_W-1:0] cw,
  output logic [P-1:0]    syndrome,
  output logic            parity
);

  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (cw[i]) syndrome = syndrome ^ P'(i);
    end
  end

  assign parity = ^cw;

endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready handshakes on both sides.
// Optional saturating error counters are built when ECC_SECDED_DEC_ERR_CNT_EN is defined.
module ecc_secded_dec_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DATA_W+parity_bits(DATA_W):0]           in_cw,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_W-1:0]                             out_data,
  output logic [parity_bits(DATA_W):0]                  out_syndrome,
  output logic                                          out_sb_err,
  output logic                                          out_db_err,
  output logic [$clog2(DATA_W+parity_bits(DATA_W)+1)-1:0] out_err_pos,
  input  logic                                          cnt_clr,
  output logic [15:0]                                   sb_cnt,
  output logic [15:0]                                   db_cnt
);

  localparam int P     = parity_bits(DATA_W);
  localparam int CW_W  = DATA_W + P + 1;
  localparam int POS_W = $clog2(CW_W);

  logic [P-1:0]      syn;
  logic              par;
  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic [P-1:0]      s1_syn;
  logic              s1_par;
  logic              s2_load;
  ecc_class_e        cls;
  logic [CW_W-1:0]   fix;
  logic [CW_W-1:0]   corrected;
  logic [DATA_W-1:0] s1_data;
  logic [POS_W-1:0]  s1_pos;

  ecc_secded_syndrome #(.CW_W(CW_W), .P(P)) u_syndrome (
    .cw       (in_cw),
    .syndrome (syn),
    .parity   (par)
  );

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= in_cw;
        s1_syn <= syn;
        s1_par <= par;
      end
    end
  end

  // An odd-weight error pointing past the codeword cannot be a single flip, so it is flagged uncorrectable.
  always_comb begin
    cls    = CLEAN;
    fix    = '0;
    s1_pos = '1;
    if (s1_par) begin
      if (int'(s1_syn) < CW_W) begin
        cls    = SB;
        fix    = {{(CW_W-1){1'b0}}, 1'b1} << s1_syn;
        s1_pos = POS_W'(s1_syn);
      end else begin
        cls = DB;
      end
    end else if (s1_syn != '0) begin
      cls = DB;
    end
  end

  assign corrected = s1_cw ^ fix;

  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int POS = data_pos(k);
    assign s1_data[k] = corrected[POS];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_sb_err   <= 1'b0;
      out_db_err   <= 1'b0;
      out_err_pos  <= '1;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= s1_data;
        out_syndrome <= {s1_par, s1_syn};
        out_sb_err   <= (cls == SB);
        out_db_err   <= (cls == DB);
        out_err_pos  <= s1_pos;
      end
    end
  end

`ifdef ECC_SECDED_DEC_ERR_CNT_EN
  // Clear has priority over an increment landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_cnt <= '0;
      db_cnt <= '0;
    end else if (cnt_clr) begin
      sb_cnt <= '0;
      db_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_sb_err && sb_cnt != 16'hFFFF) sb_cnt <= sb_cnt + 16'd1;
      if (out_db_err && db_cnt != 16'hFFFF) db_cnt <= db_cnt + 16'd1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sb_cnt = '0;
  assign db_cnt = '0;
`endif

endmodule
